// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready operand port and valid/ready result+NZCV port.
interface alu_seq_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         c_out;
  logic         v;
  logic         n;
  logic         z;
  logic         illegal;

  modport master (
    output in_valid, opcode, a, b, c_in, out_ready,
    input  in_ready, out_valid, y, c_out, v, n, z, illegal
  );

  modport slave (
    input  in_valid, opcode, a, b, c_in, out_ready,
    output in_ready, out_valid, y, c_out, v, n, z, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle handshaked shifter ALU: shifts step one bit per cycle, ALU ops finish in one cycle.
// Optional iterative shift-add multiplier (opcode 8) is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_LSL = 4'd0;
  localparam logic [3:0] OP_LSR = 4'd1;
  localparam logic [3:0] OP_ASR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
`endif

  logic [1:0]    state;
  logic [3:0]    op_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  y_r;
  logic          c_r;
  logic          v_r;
  logic          ill_r;

  logic          accept;
  logic [W:0]    sum;
  logic [W-1:0]  res_y;
  logic          res_c;
  logic          res_v;
  logic          res_ill;
  logic          go_exec;
  logic [CW-1:0] res_cnt;

`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]  mcand;
  logic [W-1:0]  hi;
  logic [W:0]    msum;

  // Partial-product accumulate; the multiplier bit is the LSB of the low half held in y_r.
  assign msum = {1'b0, hi} + (y_r[0] ? {1'b0, mcand} : {(W+1){1'b0}});
`endif

  // Returns {bit shifted out, shifted value}; ASR keeps replicating the sign bit.
  function automatic logic [W:0] shift_step(input logic [3:0] op, input logic [W-1:0] val);
    case (op)
      OP_LSL:  shift_step = {val[W-1], val[W-2:0], 1'b0};
      OP_LSR:  shift_step = {val[0], 1'b0, val[W-1:1]};
      default: shift_step = {val[0], val[W-1], val[W-1:1]};
    endcase
  endfunction

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    sum     = '0;
    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    go_exec = 1'b0;
    res_cnt = (bus.b >= W'(W)) ? CW'(W) : bus.b[CW-1:0];
    case (bus.opcode)
      OP_LSL, OP_LSR, OP_ASR: begin
        res_y   = bus.a;
        go_exec = (bus.b != '0);
      end
      OP_ADD: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.c_in};
        res_y = sum[W-1:0];
        res_c = sum[W];
        res_v = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{W{1'b0}}, bus.c_in};
        res_y = sum[W-1:0];
        res_c = sum[W];
        res_v = (bus.a[W-1] != bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_AND: res_y = bus.a & bus.b;
      OP_OR:  res_y = bus.a | bus.b;
      OP_XOR: res_y = bus.a ^ bus.b;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        res_y   = bus.b;
        go_exec = 1'b1;
        res_cnt = CW'(W);
      end
`endif
      default: res_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y_r   <= '0;
      c_r   <= 1'b0;
      v_r   <= 1'b0;
      ill_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r  <= bus.opcode;
            cnt   <= res_cnt;
            y_r   <= res_y;
            c_r   <= res_c;
            v_r   <= res_v;
            ill_r <= res_ill;
`ifdef ALU_SEQ_MUL_EN
            mcand <= bus.a;
            hi    <= '0;
`endif
            state <= go_exec ? EXEC : DONE;
          end
        end
        EXEC: begin
`ifdef ALU_SEQ_MUL_EN
          if (op_r == OP_MUL) begin
            hi  <= msum[W:1];
            y_r <= {msum[0], y_r[W-1:1]};
            c_r <= |msum[W:1];
            v_r <= |msum[W:1];
          end else begin
            {c_r, y_r} <= shift_step(op_r, y_r);
          end
`else
          {c_r, y_r} <= shift_step(op_r, y_r);
`endif
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // n/z are derived from the held result and gated so they read 0 outside a valid result.
  assign bus.out_valid = (state == DONE);
  assign bus.y         = y_r;
  assign bus.c_out     = c_r;
  assign bus.v         = v_r;
  assign bus.illegal   = ill_r;
  assign bus.n         = bus.out_valid && y_r[W-1];
  assign bus.z         = bus.out_valid && (y_r == '0);

endmodule
